i2c_master_ctrl: RTL and testbench
==================================

# i2c_master_ctrl

Parametrised I2C master. It runs a complete single-master transaction: START, 7-bit address plus R/W, then 0 to 2^BYTE_W−1 data bytes written or read, then STOP. It generates SCL and the open-drain SDA enable directly from the system clock, checks every slave ACK and ACKs/NACKs read bytes. It sits between the sensor-polling logic and the board pins, and replaces the fixed one-byte write-only controller plus its external shift register and baud unit.

## Interface
Parameters:
- CLK_DIV, 250, system clocks per SCL quarter-period (SCL = clock/(4·CLK_DIV)); ≥2
- BYTE_W, 4, width of NumBytes

Ports:
- clock  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- Go  in  1  start request, sampled when Busy=0
- ReadOrWrite  in  1  1=read, 0=write; latched with Go
- Addr  in  7  slave address; latched with Go
- NumBytes  in  BYTE_W  data byte count; latched with Go
- TxData  in  8  next write byte
- TxReq  out  1  one-clock pulse requesting next TxData
- RxData  out  8  last received byte
- RxValid  out  1  one-clock pulse, RxData updated
- Scl  out  1  SCL level (1 = released)
- SdaOut  out  1  0 = drive SDA low, 1 = release
- SdaIn  in  1  SDA pin level (externally synchronised)
- SclIn  in  1  SCL pin level; used only with I2C_CLOCK_STRETCH_EN
- Busy  out  1  transaction in progress
- Done  out  1  one-clock pulse at end of STOP
- NackErr  out  1  set on missing slave ACK; cleared on next accepted Go

## Operation
- Reset values: Scl=1, SdaOut=1, Busy=0, Done=0, NackErr=0, TxReq=0, RxValid=0, RxData=0x00, state Idle. Reset mid-transaction releases both lines immediately. No STOP is sent.
- States: Idle → Start → AddrBits → AddrAck → {WrBits → WrAck | RdBits → RdAck}* → Stop → Idle.
- Idle: Go=1 latches ReadOrWrite, Addr and NumBytes. Busy=1 from the next clock. Go while Busy=1 is ignored.
- AddrBits shifts out {Addr, ReadOrWrite} MSB first. AddrAck releases SDA and samples it. SdaIn=1 sets NackErr and goes to Stop with no data phase.
- NumBytes=0: after the address ACK go straight to Stop, which gives an address probe.
- Write: TxReq pulses in the last clock of each preceding ACK bit. TxData is latched on the next edge. A WrAck NACK sets NackErr and goes to Stop, abandoning the remaining bytes.
- Read: SDA is released for 8 bits and sampled MSB first. RxData/RxValid update in the first clock of RdAck. The master drives ACK (0) for every byte except the last, which gets NACK (1).
- Byte counter decrements after each data ACK bit. It reaches Stop at 0, with no wrap.

## Timing
- Each bit is 4 quarters Q0–Q3 of CLK_DIV clocks each:
  - Q0: SCL=0, SDA updated at its first clock.
  - Q1: SCL=0.
  - Q2: SCL=1, SdaIn sampled at its last clock.
  - Q3: SCL=1.
- Start (4 quarters): SCL=1 throughout; SDA=1 for Q0–Q1, SDA=0 for Q2–Q3.
- Stop (4 quarters): SCL=0 for Q0–Q1 and 1 for Q2–Q3; SDA=0 for Q0–Q2 and 1 for Q3.
- Done pulses in the clock after Stop Q3 ends, together with Busy falling. Go is accepted again that clock.
- Full transaction, Go edge to Done: 1 + CLK_DIV·(8 + 36·(N+1)) clocks, with N = bytes actually transferred.

## Configuration
- I2C_CLOCK_STRETCH_EN defined: at the start of Q2 the quarter counter holds while SclIn=0 (slave stretching), then resumes. The total time adds the stretch.
- Undefined: SclIn is ignored and timing is strictly as above.

## Test plan
- Write 2 bytes, CLK_DIV=4, Addr=0x48, bytes 0x01 then 0x60, slave ACKs all → SDA sequence 0x90, 0x01, 0x60. Exactly 2 TxReq pulses. Done at 1+4·116=465 clocks. NackErr=0.
- Read 2 bytes from 0x48, slave returns 0x19 then 0x80 → 2 RxValid pulses with those values. Master ACKs byte 1 and NACKs byte 2.
- Address NACK: SdaIn=1 in AddrAck → NackErr=1, no TxReq, Stop follows immediately. Done at 1+4·44=177 clocks.
- NumBytes=0 probe with ACK → Start, 0x91 address, Stop. Done at 177 clocks. Go held high during Busy starts no second transaction.
- Reset asserted mid-byte → Scl=1, SdaOut=1, Busy=0 the same clock. A following Go runs a clean transaction.
- Stretch build: hold SclIn=0 for 20 clocks at the AddrAck Q2 → Done is delayed by exactly 20 clocks.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
//   Single-master I2C controller. Runs one complete transaction per Go:
//   START, {Addr, ReadOrWrite}, 0..2^BYTE_W-1 data bytes (write or read),
//   then STOP. SCL and the open-drain SDA enable are generated straight from
//   the system clock; every bit is four quarters of CLK_DIV clocks.
//
// Parameters
//   CLK_DIV  system clocks per SCL quarter-period (>= 2)
//   BYTE_W   width of NumBytes
//
// Ports
//   clock, Reset          system clock / async active-high reset
//   Go                    start request (sampled while Busy=0)
//   ReadOrWrite, Addr,
//   NumBytes              transaction descriptor, latched with Go
//   TxData / TxReq        next write byte / one-clock request for it
//   RxData / RxValid      last read byte / one-clock update strobe
//   Scl, SdaOut           line levels (1 = released)
//   SdaIn, SclIn          pin levels (SclIn only used with stretching)
//   Busy, Done, NackErr   status
//
// Build option
//   I2C_CLOCK_STRETCH_EN  hold the quarter counter at the start of Q2 while
//                         SclIn=0 (slave clock stretching).

module i2c_master_ctrl #(
  parameter int CLK_DIV = 250,
  parameter int BYTE_W  = 4
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Go,
  input  logic              ReadOrWrite,
  input  logic [6:0]        Addr,
  input  logic [BYTE_W-1:0] NumBytes,
  input  logic [7:0]        TxData,
  output logic              TxReq,
  output logic [7:0]        RxData,
  output logic              RxValid,
  output logic              Scl,
  output logic              SdaOut,
  input  logic              SdaIn,
  input  logic              SclIn,
  output logic              Busy,
  output logic              Done,
  output logic              NackErr
);

  localparam int CW = $clog2(CLK_DIV + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_BITS, S_ADDR_ACK,
    S_WR_BITS, S_WR_ACK, S_RD_BITS, S_RD_ACK, S_STOP
  } state_t;

  state_t            state_q;
  logic [1:0]        q_q;      // quarter within the current bit
  logic [CW-1:0]     cnt_q;    // clocks left in the current quarter
  logic [2:0]        bit_q;
  logic [7:0]        sh_q;     // tx shift (MSB is on the line) / rx shift
  logic              rw_q;
  logic [BYTE_W-1:0] rem_q;    // data bytes still to transfer
  logic              nack_q;   // SDA level seen in the last ACK bit
  logic              scl_q, sda_q, busy_q, done_q, nackerr_q;
  logic              txreq_q, rxvalid_q;
  logic [7:0]        rxdata_q;
  logic              hold;

`ifdef I2C_CLOCK_STRETCH_EN
  assign hold = (state_q != S_IDLE) && (q_q == 2'd2) &&
                (cnt_q == CW'(CLK_DIV - 1)) && !SclIn;
`else
  logic unused_sclin;
  assign unused_sclin = SclIn;
  assign hold = 1'b0;
`endif

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      q_q       <= 2'd0;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      sh_q      <= 8'h00;
      rw_q      <= 1'b0;
      rem_q     <= '0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nackerr_q <= 1'b0;
      txreq_q   <= 1'b0;
      rxvalid_q <= 1'b0;
      rxdata_q  <= 8'h00;
    end else begin
      txreq_q   <= 1'b0;
      rxvalid_q <= 1'b0;
      done_q    <= 1'b0;
      if (state_q == S_IDLE) begin
        if (Go) begin
          state_q   <= S_START;
          busy_q    <= 1'b1;
          nackerr_q <= 1'b0;
          rw_q      <= ReadOrWrite;
          rem_q     <= NumBytes;
          sh_q      <= {Addr, ReadOrWrite};
          q_q       <= 2'd0;
          bit_q     <= 3'd0;
          // One extra clock in Start Q0 accounts for the accept cycle; the
          // lines are idle-high there so it is invisible on the bus.
          cnt_q     <= CW'(CLK_DIV);
        end
      end else if (!hold) begin
        // Next write byte is requested in the last clock of an ACKed ACK bit
        // that will be followed by another write byte.
        if (q_q == 2'd3 && cnt_q == CW'(1) && !nack_q &&
            ((state_q == S_ADDR_ACK && !rw_q && rem_q != '0) ||
             (state_q == S_WR_ACK && rem_q > BYTE_W'(1))))
          txreq_q <= 1'b1;

        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          cnt_q <= CW'(CLK_DIV - 1);
          if (q_q != 2'd3) begin
            q_q   <= q_q + 2'd1;
            scl_q <= (state_q == S_START) || (q_q != 2'd0);
            if (state_q == S_START) sda_q <= (q_q == 2'd0);
            if (state_q == S_STOP)  sda_q <= (q_q == 2'd2);
            // End of Q2: slave-driven SDA is stable under SCL high.
            if (q_q == 2'd2) begin
              if (state_q == S_ADDR_ACK || state_q == S_WR_ACK) nack_q <= SdaIn;
              if (state_q == S_RD_BITS) sh_q <= {sh_q[6:0], SdaIn};
            end
          end else begin
            q_q   <= 2'd0;
            scl_q <= 1'b0;
            unique case (state_q)
              S_START: begin
                state_q <= S_ADDR_BITS;
                bit_q   <= 3'd0;
                sda_q   <= sh_q[7];
              end
              S_ADDR_BITS, S_WR_BITS: begin
                if (bit_q == 3'd7) begin
                  state_q <= (state_q == S_ADDR_BITS) ? S_ADDR_ACK : S_WR_ACK;
                  sda_q   <= 1'b1;
                end else begin
                  bit_q <= bit_q + 3'd1;
                  sh_q  <= {sh_q[6:0], 1'b0};
                  sda_q <= sh_q[6];
                end
              end
              S_ADDR_ACK: begin
                bit_q <= 3'd0;
                if (nack_q || rem_q == '0) begin
                  nackerr_q <= nack_q;
                  state_q   <= S_STOP;
                  sda_q     <= 1'b0;
                end else if (rw_q) begin
                  state_q <= S_RD_BITS;
                  sda_q   <= 1'b1;
                end else begin
                  state_q <= S_WR_BITS;
                  sh_q    <= TxData;
                  sda_q   <= TxData[7];
                end
              end
              S_WR_ACK: begin
                rem_q <= rem_q - BYTE_W'(1);
                bit_q <= 3'd0;
                if (nack_q || rem_q == BYTE_W'(1)) begin
                  nackerr_q <= nack_q;
                  state_q   <= S_STOP;
                  sda_q     <= 1'b0;
                end else begin
                  state_q <= S_WR_BITS;
                  sh_q    <= TxData;
                  sda_q   <= TxData[7];
                end
              end
              S_RD_BITS: begin
                if (bit_q == 3'd7) begin
                  state_q   <= S_RD_ACK;
                  rxdata_q  <= sh_q;
                  rxvalid_q <= 1'b1;
                  // ACK every byte but the last, which is NACKed.
                  sda_q     <= (rem_q == BYTE_W'(1));
                end else begin
                  bit_q <= bit_q + 3'd1;
                end
              end
              S_RD_ACK: begin
                rem_q <= rem_q - BYTE_W'(1);
                bit_q <= 3'd0;
                if (rem_q == BYTE_W'(1)) begin
                  state_q <= S_STOP;
                  sda_q   <= 1'b0;
                end else begin
                  state_q <= S_RD_BITS;
                  sda_q   <= 1'b1;
                end
              end
              S_STOP: begin
                state_q <= S_IDLE;
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      end
    end
  end

  assign Scl     = scl_q;
  assign SdaOut  = sda_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign NackErr = nackerr_q;
  assign TxReq   = txreq_q;
  assign RxValid = rxvalid_q;
  assign RxData  = rxdata_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: table of transactions, a bus-level slave model
// with a byte/ACK scoreboard, and hand sequences for async reset.
module tb_i2c_master_ctrl;

  localparam int CD = 4;
  localparam int BW = 4;
`ifdef I2C_CLOCK_STRETCH_EN
  localparam int STR = 20;
`else
  localparam int STR = 0;
`endif

  logic          clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Go = 1'b0;
  logic          ReadOrWrite = 1'b0;
  logic [6:0]    Addr = 7'h00;
  logic [BW-1:0] NumBytes = '0;
  logic [7:0]    TxData = 8'h00;
  logic          SclIn = 1'b1;
  logic          SdaIn;
  logic          TxReq, RxValid, Scl, SdaOut, Busy, Done, NackErr;
  logic [7:0]    RxData;

  logic drv = 1'b1;                 // slave's open-drain SDA enable
  assign SdaIn = SdaOut & drv;

  i2c_master_ctrl #(.CLK_DIV(CD), .BYTE_W(BW)) dut (
    .clock(clock), .Reset(Reset), .Go(Go), .ReadOrWrite(ReadOrWrite),
    .Addr(Addr), .NumBytes(NumBytes), .TxData(TxData), .TxReq(TxReq),
    .RxData(RxData), .RxValid(RxValid), .Scl(Scl), .SdaOut(SdaOut),
    .SdaIn(SdaIn), .SclIn(SclIn), .Busy(Busy), .Done(Done), .NackErr(NackErr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { logic [7:0] b; logic ack; } exp_t;
  exp_t       sb_q[$];
  logic [7:0] rx_q[$];

  // ---------------- slave / bus monitor ----------------
  logic       slv_nack = 1'b0;
  int         rd_n = 0;
  logic [7:0] rdb [2];
  logic       in_txn = 1'b0, rw_s = 1'b0, scl_p = 1'b1, sda_p = 1'b1, line;
  logic [7:0] msh = 8'h00;
  int         bitn = 0, frame = 0;

  initial begin
    forever begin
      @(negedge clock);
      line = SdaIn;
      if (Reset) begin
        in_txn = 1'b0; drv = 1'b1;
      end else if (Scl && scl_p && sda_p && !line) begin
        in_txn = 1'b1; bitn = -1; frame = 0; rw_s = 1'b0;
      end else if (Scl && scl_p && !sda_p && line) begin
        in_txn = 1'b0; drv = 1'b1;
      end else if (in_txn && Scl && !scl_p) begin
        if (bitn >= 0 && bitn < 8) msh = {msh[6:0], line};
        else if (bitn == 8) begin
          if (frame == 0) rw_s = msh[0];
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_byte: unexpected byte %h ack %b", msh, line);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("bus_byte%0d", frame), {23'd0, msh, line}, {23'd0, e.b, e.ack});
          end
        end
      end else if (in_txn && !Scl && scl_p) begin
        if (bitn == 8) begin bitn = 0; frame++; end
        else bitn++;
        if (bitn == 8) drv = (frame == 0) ? slv_nack : rw_s;
        else if (rw_s && frame >= 1 && frame - 1 < rd_n) drv = rdb[frame-1][7-bitn];
        else drv = 1'b1;
      end
      scl_p = Scl;
      sda_p = line;
    end
  end

  // ---------------- transaction table ----------------
  typedef struct {
    logic          rw;
    logic [6:0]    addr;
    logic [BW-1:0] n;
    logic [7:0]    d0, d1;
    logic          nack_addr;
    int            go_hold;    // clocks Go stays high after acceptance
    int            stretch;    // SclIn low clocks at AddrAck Q2
    int            exp_cyc;
    logic          exp_nack;
    int            exp_tx, exp_rx;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  task automatic run_vec(input vec_t v, input string nm);
    int   cyc, txc, rxc, tidx, sclr, stl;
    logic sp, done;
    exp_t e;
    cyc = 0; txc = 0; rxc = 0; tidx = 0; sclr = 0; stl = 0; done = 1'b0;
    slv_nack = v.nack_addr;
    rd_n     = v.rw ? int'(v.n) : 0;
    rdb[0]   = v.d0;
    rdb[1]   = v.d1;
    e.b = {v.addr, v.rw}; e.ack = v.nack_addr;
    sb_q.push_back(e);
    if (!v.nack_addr)
      for (int k = 0; k < int'(v.n); k++) begin
        e.b   = (k == 0) ? v.d0 : v.d1;
        e.ack = v.rw && (k == int'(v.n) - 1);
        sb_q.push_back(e);
        if (v.rw) rx_q.push_back(e.b);
      end
    @(negedge clock);
    ReadOrWrite = v.rw; Addr = v.addr; NumBytes = v.n; Go = 1'b1;
    @(posedge clock); #1;
    if (v.go_hold == 0) Go = 1'b0;
    chk({nm, ":busy_after_go"}, {31'd0, Busy}, 32'd1);
    chk({nm, ":nackerr_cleared"}, {31'd0, NackErr}, 32'd0);
    sp = Scl;
    while (!done && cyc < 3000) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == v.go_hold) Go = 1'b0;
      if (TxReq) begin
        txc++;
        TxData = (tidx == 0) ? v.d0 : v.d1;
        tidx++;
      end
      if (RxValid) begin
        rxc++;
        if (rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s:rxdata: unexpected RxValid with %h", nm, RxData);
        end else chk({nm, ":rxdata"}, {24'd0, RxData}, {24'd0, rx_q.pop_front()});
      end
      if (Scl && !sp) sclr++;
      if (stl > 0) begin
        stl--;
        if (stl == 0) SclIn = 1'b1;
      end else if (v.stretch > 0 && Scl && !sp && sclr == 9) begin
        SclIn = 1'b0;
        stl   = v.stretch;
      end
      sp = Scl;
      if (Done) done = 1'b1;
    end
    SclIn = 1'b1;
    chk({nm, ":done_seen"}, {31'd0, done}, 32'd1);
    chk({nm, ":cycles"}, cyc, v.exp_cyc);
    chk({nm, ":nackerr"}, {31'd0, NackErr}, {31'd0, v.exp_nack});
    chk({nm, ":busy_low"}, {31'd0, Busy}, 32'd0);
    chk({nm, ":txreq_count"}, txc, v.exp_tx);
    chk({nm, ":rxvalid_count"}, rxc, v.exp_rx);
    chk({nm, ":bytes_left"}, sb_q.size(), 0);
    chk({nm, ":rx_left"}, rx_q.size(), 0);
    sb_q.delete();
    rx_q.delete();
    Go = 1'b0;
    @(posedge clock); #1;
    chk({nm, ":done_pulse"}, {31'd0, Done}, 32'd0);
    chk({nm, ":no_restart"}, {31'd0, Busy}, 32'd0);
    repeat (3) @(posedge clock);
  endtask

  initial begin
    //          rw    addr   n    d0     d1     nack  hold stretch cyc       nack  tx rx
    vt[0] = '{1'b0, 7'h48, 4'd2, 8'h01, 8'h60, 1'b0, 0,   0,  465,       1'b0, 2, 0};
    vt[1] = '{1'b1, 7'h48, 4'd2, 8'h19, 8'h80, 1'b0, 0,   0,  465,       1'b0, 0, 2};
    vt[2] = '{1'b0, 7'h48, 4'd2, 8'h01, 8'h60, 1'b1, 0,   0,  177,       1'b1, 0, 0};
    vt[3] = '{1'b1, 7'h48, 4'd0, 8'h00, 8'h00, 1'b0, 100, 0,  177,       1'b0, 0, 0};
    vt[4] = '{1'b0, 7'h3C, 4'd1, 8'hA5, 8'h00, 1'b0, 0,   0,  321,       1'b0, 1, 0};
    vt[5] = '{1'b1, 7'h50, 4'd1, 8'h5A, 8'h00, 1'b0, 0,   0,  321,       1'b0, 0, 1};
    vt[6] = '{1'b1, 7'h2A, 4'd3, 8'hFF, 8'hFF, 1'b1, 0,   0,  177,       1'b1, 0, 0};
    vt[7] = '{1'b0, 7'h48, 4'd0, 8'h00, 8'h00, 1'b0, 0,   20, 177 + STR, 1'b0, 0, 0};

    Reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset:scl", {31'd0, Scl}, 32'd1);
    chk("reset:sda", {31'd0, SdaOut}, 32'd1);
    chk("reset:busy_done_nack", {29'd0, Busy, Done, NackErr}, 32'd0);
    chk("reset:txreq_rxvalid", {30'd0, TxReq, RxValid}, 32'd0);
    chk("reset:rxdata", {24'd0, RxData}, 32'd0);
    #1 Reset = 1'b0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < NV; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of the address byte, with SCL and SDA both low.
    begin
      int k;
      k = 0;
      slv_nack = 1'b0; rd_n = 0;
      @(negedge clock);
      ReadOrWrite = 1'b0; Addr = 7'h48; NumBytes = 4'd2; Go = 1'b1;
      @(posedge clock); #1;
      Go = 1'b0;
      while (!(Scl == 1'b0 && SdaOut == 1'b0) && k < 200) begin
        @(posedge clock); #1;
        k++;
      end
      chk("midreset:lines_low", {31'd0, Busy && !Scl && !SdaOut}, 32'd1);
      #2 Reset = 1'b1;
      #1;
      chk("midreset:scl", {31'd0, Scl}, 32'd1);
      chk("midreset:sda", {31'd0, SdaOut}, 32'd1);
      chk("midreset:busy", {31'd0, Busy}, 32'd0);
      @(negedge clock);
      @(posedge clock);
      #2 Reset = 1'b0;
      sb_q.delete();
      rx_q.delete();
      repeat (2) @(posedge clock);
      run_vec(vt[0], "after_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
